// File: rtl/ysyx_25040109_trap_ctrl.sv
// Trap sequencer and CSR write-port arbiter: runs the ecall mepc/mcause/redirect
// sequence, resolves mret redirects, and passes ordinary CSR writes to the port.
module ysyx_25040109_trap_ctrl #(
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]      ECALL_CAUSE = DATA_WIDTH'(11)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_valid,
  input  logic                  is_ecall,
  input  logic                  is_mret,
  input  logic                  is_csr_wr,
  input  logic [DATA_WIDTH-1:0] inst_pc,
  input  logic [11:0]           csr_addr_in,
  input  logic [DATA_WIDTH-1:0] csr_wdata_in,
  input  logic [DATA_WIDTH-1:0] mepc_in,
  input  logic [DATA_WIDTH-1:0] mtvec_in,
  output logic                  csr_we,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  stall,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] trap_cnt
);

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    W_MEPC   = 2'd1,
    W_MCAUSE = 2'd2,
    REDIR    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] epc_q, epc_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  accept;
  logic                  take_ecall;
  logic                  take_mret;
  logic                  take_csr;

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + DATA_WIDTH'(1);
  endfunction

  // Priority decode: ecall beats mret beats a plain CSR write.
  assign accept     = rst_n && (state_q == IDLE) && inst_valid;
  assign take_ecall = accept && is_ecall;
  assign take_mret  = accept && !is_ecall && is_mret;
  assign take_csr   = accept && !is_ecall && !is_mret && is_csr_wr;

  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    cnt_d          = cnt_q;
    csr_we         = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    unique case (state_q)
      IDLE: begin
        if (take_ecall) begin
          stall   = 1'b1;
          epc_d   = inst_pc;
          cnt_d   = sat_inc(cnt_q);
          state_d = W_MEPC;
        end else if (take_mret) begin
          redirect_valid = 1'b1;
          redirect_pc    = mepc_in;
        end else if (take_csr) begin
          csr_we    = 1'b1;
          csr_addr  = csr_addr_in;
          csr_wdata = csr_wdata_in;
        end
      end
      W_MEPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = epc_q;
        stall     = 1'b1;
        state_d   = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = ECALL_CAUSE;
        stall     = 1'b1;
        state_d   = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = mtvec_in;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs stay quiet for the whole time reset is held, whatever the inputs.
    if (!rst_n) begin
      csr_we         = 1'b0;
      csr_addr       = '0;
      csr_wdata      = '0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  assign busy     = rst_n && (state_q != IDLE);
  assign trap_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_trap_ctrl.sv
// Scoreboard bench for the trap sequencer: a schedule-of-actions model predicts each
// cycle's port outputs; a negedge monitor pops and compares them for two widths.
module tb_ysyx_25040109_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inst_valid = 1'b0, is_ecall = 1'b0, is_mret = 1'b0, is_csr_wr = 1'b0;
  logic [31:0] inst_pc = '0, csr_wdata_in = '0, mtvec_in = '0, rf_mepc = '0;
  logic [11:0] csr_addr_in = '0;

  logic        csr_we, stall, redirect_valid, busy;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, redirect_pc, trap_cnt;

  logic        s_we, s_stall, s_rv, s_busy;
  logic [11:0] s_addr;
  logic [7:0]  s_wdata, s_rpc, s_cnt;

  always #5 clk = ~clk;

  ysyx_25040109_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .is_ecall(is_ecall),
    .is_mret(is_mret), .is_csr_wr(is_csr_wr), .inst_pc(inst_pc),
    .csr_addr_in(csr_addr_in), .csr_wdata_in(csr_wdata_in), .mepc_in(rf_mepc),
    .mtvec_in(mtvec_in), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .trap_cnt(trap_cnt)
  );

  // Narrow instance shares the stimulus so counter saturation is reachable quickly.
  ysyx_25040109_trap_ctrl #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .is_ecall(is_ecall),
    .is_mret(is_mret), .is_csr_wr(is_csr_wr), .inst_pc(inst_pc[7:0]),
    .csr_addr_in(csr_addr_in), .csr_wdata_in(csr_wdata_in[7:0]), .mepc_in(rf_mepc[7:0]),
    .mtvec_in(mtvec_in[7:0]), .csr_we(s_we), .csr_addr(s_addr), .csr_wdata(s_wdata),
    .stall(s_stall), .redirect_valid(s_rv), .redirect_pc(s_rpc),
    .busy(s_busy), .trap_cnt(s_cnt)
  );

  // Register-file stand-in: mepc is written by the CSR port on the edge.
  always @(posedge clk)
    if (csr_we && csr_addr == 12'h341) rf_mepc <= csr_wdata;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
    logic [31:0] cnt;
    logic [7:0]  cnt8;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;

  // Reference model: a queue of pending trap actions (1=mepc write, 2=mcause write, 3=redirect).
  int          sched[$];
  logic [31:0] m_epc = '0;
  logic [31:0] m_mepc = '0;
  longint      m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("csr_we",         32'(csr_we),         32'(e.we));
      chk("csr_addr",       32'(csr_addr),       32'(e.addr));
      chk("csr_wdata",      csr_wdata,           e.wdata);
      chk("stall",          32'(stall),          32'(e.stall));
      chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
      chk("redirect_pc",    redirect_pc,         e.rpc);
      chk("busy",           32'(busy),           32'(e.busy));
      chk("trap_cnt",       trap_cnt,            e.cnt);
      chk("n8_csr_we",      32'(s_we),           32'(e.we));
      chk("n8_csr_addr",    32'(s_addr),         32'(e.addr));
      chk("n8_csr_wdata",   32'(s_wdata),        32'(e.wdata[7:0]));
      chk("n8_stall",       32'(s_stall),        32'(e.stall));
      chk("n8_redirect",    32'(s_rv),           32'(e.rv));
      chk("n8_redirect_pc", 32'(s_rpc),          32'(e.rpc[7:0]));
      chk("n8_busy",        32'(s_busy),         32'(e.busy));
      chk("n8_trap_cnt",    32'(s_cnt),          32'(e.cnt8));
    end
  end

  // Predict this cycle's outputs, hand them to the monitor, then advance the model at the edge.
  task automatic step();
    exp_t e;
    logic take;
    e = '0;
    if (rst_n) begin
      if (sched.size() > 0) begin
        e.busy = 1'b1;
        case (sched[0])
          1: begin e.we = 1'b1; e.addr = 12'h341; e.wdata = m_epc; e.stall = 1'b1; end
          2: begin e.we = 1'b1; e.addr = 12'h342; e.wdata = 32'd11; e.stall = 1'b1; end
          default: begin e.rv = 1'b1; e.rpc = mtvec_in; end
        endcase
      end else if (inst_valid) begin
        if (is_ecall) e.stall = 1'b1;
        else if (is_mret) begin e.rv = 1'b1; e.rpc = m_mepc; end
        else if (is_csr_wr) begin e.we = 1'b1; e.addr = csr_addr_in; e.wdata = csr_wdata_in; end
      end
      e.cnt  = m_cnt[31:0];
      e.cnt8 = (m_cnt > 255) ? 8'hFF : m_cnt[7:0];
    end
    exp_q.push_back(e);
    take = rst_n && sched.size() == 0 && inst_valid && is_ecall;
    @(posedge clk);
    if (e.we && e.addr == 12'h341) m_mepc = e.wdata;
    if (!rst_n) begin
      sched.delete();
      m_cnt = 0;
      m_epc = '0;
    end else if (sched.size() > 0) begin
      void'(sched.pop_front());
    end else if (take) begin
      sched = '{1, 2, 3};
      m_epc = inst_pc;
      m_cnt++;
    end
    #1;
  endtask

  task automatic set_inst(input logic v, input logic ec, input logic mr, input logic cw,
                          input logic [31:0] pc, input logic [11:0] a, input logic [31:0] d);
    inst_valid = v; is_ecall = ec; is_mret = mr; is_csr_wr = cw;
    inst_pc = pc; csr_addr_in = a; csr_wdata_in = d;
  endtask

  task automatic idle_inst();
    set_inst(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    mtvec_in = 32'h80000100;

    // Reset held with an ecall presented: everything quiet, then accepted on the first edge.
    set_inst(1'b1, 1'b1, 1'b0, 1'b0, 32'h80000010, 12'h0, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    set_inst(1'b1, 1'b0, 1'b1, 1'b1, 32'h1234, 12'h305, 32'hDEAD);
    step(); step(); step();
    // First handler instruction: mret must see the mepc just written.
    set_inst(1'b1, 1'b0, 1'b1, 1'b0, 32'h80000100, 12'h0, 32'h0);
    step();

    set_inst(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 12'h341, 32'h80000014);
    step();
    set_inst(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 12'h0, 32'h0);
    step();
    set_inst(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 12'h305, 32'h80000200);
    step();

    // CSR write presented while the trap owns the port.
    set_inst(1'b1, 1'b1, 1'b0, 1'b0, 32'h80000020, 12'h0, 32'h0);
    step();
    set_inst(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 12'h305, 32'h80000200);
    step(); step(); step();

    // ecall and CSR write together: the write is dropped.
    set_inst(1'b1, 1'b1, 1'b0, 1'b1, 32'h80000030, 12'h305, 32'h55AA55AA);
    step();
    idle_inst();
    step();
    // Reset pulse while writing mcause aborts the sequence with no redirect.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step();

    for (int i = 0; i < 300; i++) begin
      set_inst($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, $urandom,
               ($urandom_range(0, 3) == 0) ? 12'h341 : 12'($urandom), $urandom);
      mtvec_in = $urandom;
      step();
    end

    // Back-to-back ecalls drive the narrow counter into saturation.
    mtvec_in = 32'h80000100;
    for (int i = 0; i < 262; i++) begin
      set_inst(1'b1, 1'b1, 1'b0, 1'b0, 32'h80000000 + 32'(i * 4), 12'h0, 32'h0);
      step();
      idle_inst();
      step(); step(); step();
    end
    step(); step();

    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25040109_trap_ctrl.md
# ysyx_25040109_trap_ctrl

Trap sequencer and CSR write-port arbiter for the single-cycle core. It sits between the decode/execute stage and the register file's single CSR write port. On `ecall` it stalls the core and writes `mepc` then `mcause` through that port, then redirects the PC to `mtvec`. On `mret` it redirects to `mepc`. At all other times it passes ordinary CSR-write instructions through to the port.

## Interface
- `DATA_WIDTH`, default 32: width of PC, CSR data and counter.
- `ECALL_CAUSE`, default 32'd11: value written to `mcause` on `ecall` (environment call from M-mode).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `inst_valid`  in  1  the current instruction is valid this cycle.
- `is_ecall`  in  1  the current instruction is `ecall`.
- `is_mret`  in  1  the current instruction is `mret`.
- `is_csr_wr`  in  1  the current instruction writes a CSR (csrrw/csrrs/...).
- `inst_pc`  in  DATA_WIDTH  PC of the current instruction.
- `csr_addr_in`  in  12  CSR address from the instruction.
- `csr_wdata_in`  in  DATA_WIDTH  CSR write data computed by the core.
- `mepc_in`  in  DATA_WIDTH  current `mepc` from the register file.
- `mtvec_in`  in  DATA_WIDTH  current `mtvec` from the register file.
- `csr_we`  out  1  write enable to the register-file CSR port.
- `csr_addr`  out  12  address to the register-file CSR port.
- `csr_wdata`  out  DATA_WIDTH  data to the register-file CSR port.
- `stall`  out  1  core must hold its PC and suppress GPR writeback.
- `redirect_valid`  out  1  PC loads `redirect_pc` at the next edge instead of PC+4.
- `redirect_pc`  out  DATA_WIDTH  redirect target.
- `busy`  out  1  FSM is not in IDLE.
- `trap_cnt`  out  DATA_WIDTH  number of `ecall` traps taken; saturates at all-ones.

## Operation
- FSM states: IDLE, W_MEPC, W_MCAUSE, REDIR. Encoding is free.
- Registers: `state`, `epc_q` (latched trap PC), `trap_cnt`.
- An instruction is accepted only in IDLE with `inst_valid`=1.
- Decode priority when several flags are set: `is_ecall` > `is_mret` > `is_csr_wr`. Lower-priority flags are ignored.
- IDLE + `ecall`:
  - `stall`=1 combinationally in the same cycle.
  - `epc_q` <= `inst_pc`.
  - `trap_cnt` increments by 1, unless it is already all-ones.
  - Next state is W_MEPC.
- W_MEPC: `csr_we`=1, `csr_addr`=12'h341, `csr_wdata`=`epc_q`, `stall`=1. Next state is W_MCAUSE.
- W_MCAUSE: `csr_we`=1, `csr_addr`=12'h342, `csr_wdata`=`ECALL_CAUSE`, `stall`=1. Next state is REDIR.
- REDIR: `redirect_valid`=1, `redirect_pc`=`mtvec_in`, `stall`=0, `csr_we`=0. Next state is IDLE.
- IDLE + `mret`: combinational `redirect_valid`=1, `redirect_pc`=`mepc_in`, `stall`=0. No state change.
- IDLE + `is_csr_wr`: combinational pass-through. `csr_we`=1, `csr_addr`=`csr_addr_in`, `csr_wdata`=`csr_wdata_in`.
- In W_MEPC, W_MCAUSE and REDIR, `inst_valid` and all instruction flags are ignored. The core is stalled or being redirected during these states.
- When `csr_we`=0, `csr_addr` and `csr_wdata` drive 0. When `redirect_valid`=0, `redirect_pc` drives 0.
- This block never writes `mstatus`.

## Timing
- Reset (`rst_n`=0):
  - Asynchronously sets state=IDLE, `epc_q`=0, `trap_cnt`=0.
  - While `rst_n`=0, `csr_we`, `stall`, `redirect_valid` and `busy` are forced to 0 regardless of inputs. Address, data and PC outputs are 0.
- `ecall` accepted at cycle T produces:
  - T: `stall`=1.
  - T+1: `mepc` write.
  - T+2: `mcause` write.
  - T+3: redirect to `mtvec`.
  - T+4: IDLE, with the PC at the handler.
  - Total `ecall` latency is 4 cycles; `busy`=1 during T+1..T+3.
- The `mepc` written at T+1 is visible on `mepc_in` from T+2, because the register file writes on the edge.
- `mret` and CSR writes add zero cycles.
- Back-to-back:
  - An `ecall` presented at T+4 (IDLE) is accepted normally.
  - An `mret` issued as the first handler instruction sees the `mepc` written by the preceding trap.
- Reset asserted mid-sequence (for example in W_MCAUSE) aborts the sequence:
  - Writes already issued are not undone.
  - No further writes or redirect occur.
- `trap_cnt` updates at the accept edge: an `ecall` at T shows the new count from T+1.

## Test plan
- Reset with `inst_valid`=1 and `is_ecall`=1 held -> `stall`, `csr_we`, `redirect_valid` and `busy` are 0, `trap_cnt`=0. After release, the `ecall` is accepted on the first edge.
- `ecall` at `inst_pc`=0x80000010, `mtvec_in`=0x80000100 -> sequence runs:
  - T: `stall`=1.
  - T+1: write 0x341 <= 0x80000010.
  - T+2: write 0x342 <= 11.
  - T+3: redirect to 0x80000100 with `stall`=0.
  - `trap_cnt`=1 from T+1.
- `mret` in IDLE with `mepc_in`=0x80000014 -> same-cycle `redirect_valid`=1, `redirect_pc`=0x80000014; `stall`=0, `csr_we`=0, state stays IDLE.
- CSR write `csr_addr_in`=0x305, `csr_wdata_in`=0x80000200 in IDLE -> same-cycle `csr_we`=1 with matching address and data. The same request presented in W_MEPC -> the port carries 0x341 and `epc_q` instead.
- `is_ecall`=1 and `is_csr_wr`=1 together -> the `ecall` sequence runs and the CSR write is dropped. `rst_n` pulsed low during W_MCAUSE -> immediately IDLE with outputs 0, and no redirect follows.
- Preload `trap_cnt` to all-ones via repeated `ecall`s (or force) and issue one more `ecall` -> `trap_cnt` stays 0xFFFFFFFF while the sequence still completes.
